// File: rtl/jtvigil_scroll_regs.sv
// jtvigil_scroll_regs
// CPU-visible scroll position registers for up to four background layers,
// plus the vertical-blank interrupt generator.
//
// Optional feature, selected at compile time with the macro JTVIGIL_SCRDBUF_EN:
//   defined   - CPU writes land in per-channel shadow registers and are copied
//               to the active registers on the LVBL falling edge (only for
//               channels written since the last copy).
//   undefined - CPU writes update the active registers directly.
//
// Parameters
//   NCH      number of scroll channels (1..4)
//   SW       scroll position width per channel (9..16)
//   BASE     I/O port of channel 0 low byte; block spans BASE..BASE+2*NCH-1
//   INT_HOLD interrupt auto-clear timeout, counted in cpu_cen pulses
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   cpu_cen    CPU clock enable (only used to time the interrupt auto-clear)
//   A          I/O port address
//   cpu_dout   CPU write data
//   io_wr      I/O write strobe, acted on at its rising edge only
//   io_rd      I/O read strobe
//   iack       interrupt acknowledge
//   LVBL       vertical blank, active low
//   dip_pause  low = game paused, no interrupts raised
//   scrpos     packed active scroll positions, channel n at [n*SW +: SW]
//   cpu_din    read-back data, 8'hFF when not reading an in-range port
//   int_n      vertical-blank interrupt, active low
module jtvigil_scroll_regs #(
  parameter int          NCH      = 2,
  parameter int          SW       = 11,
  parameter logic [7:0]  BASE     = 8'h80,
  parameter int          INT_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cen,
  input  logic [7:0]        A,
  input  logic [7:0]        cpu_dout,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic              iack,
  input  logic              LVBL,
  input  logic              dip_pause,
  output logic [NCH*SW-1:0] scrpos,
  output logic [7:0]        cpu_din,
  output logic              int_n
);

  localparam int         CW    = $clog2(INT_HOLD + 1);
  localparam logic [7:0] NPORT = 8'(2 * NCH);

  // Address decode. The subtraction wraps, so ports below BASE become large
  // indices and fall out of range as well.
  logic [7:0] index;
  logic       in_range;
  logic [1:0] ch;
  logic       hi;

  assign index    = A - BASE;
  assign in_range = index < NPORT;
  assign ch       = index[2:1];
  assign hi       = index[0];

  // Edge history
  logic wr_q, lvbl_q;
  logic wr_edge, lvbl_fall;

  assign wr_edge   = io_wr & ~wr_q;
  assign lvbl_fall = lvbl_q & ~LVBL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      lvbl_q <= 1'b0;
    end else begin
      wr_q   <= io_wr;
      lvbl_q <= LVBL;
    end
  end

  // Byte merge of a write into an existing register value
  function automatic logic [SW-1:0] merge(input logic [SW-1:0] old,
                                          input logic          sel_hi,
                                          input logic [7:0]    din);
    logic [SW-1:0] res;
    res = old;
    if (sel_hi) res[SW-1:8] = din[SW-9:0];
    else        res[7:0]    = din;
    return res;
  endfunction

  logic [SW-1:0] act [NCH];
  logic [SW-1:0] rd_reg;

`ifdef JTVIGIL_SCRDBUF_EN
  logic [SW-1:0]  shd [NCH];
  logic [NCH-1:0] dirty;

  // Commit and write may coincide: the commit copies the old shadow value
  // and the write then re-marks the channel dirty for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        act[c] <= '0;
        shd[c] <= '0;
      end
      dirty <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (lvbl_fall && dirty[c]) begin
          act[c]   <= shd[c];
          dirty[c] <= 1'b0;
        end
        if (wr_edge && in_range && ch == 2'(c)) begin
          shd[c]   <= merge(shd[c], hi, cpu_dout);
          dirty[c] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_reg = '0;
    for (int c = 0; c < NCH; c++)
      if (ch == 2'(c)) rd_reg = shd[c];
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) act[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (wr_edge && in_range && ch == 2'(c))
          act[c] <= merge(act[c], hi, cpu_dout);
    end
  end

  always_comb begin
    rd_reg = '0;
    for (int c = 0; c < NCH; c++)
      if (ch == 2'(c)) rd_reg = act[c];
  end
`endif

  always_comb begin
    for (int c = 0; c < NCH; c++) scrpos[c*SW +: SW] = act[c];
  end

  // Read-back, registered; the high byte is zero-extended
  logic [15:0] rd_ext;
  assign rd_ext = 16'(rd_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cpu_din <= 8'hFF;
    else if (io_rd && in_range) cpu_din <= hi ? rd_ext[15:8] : rd_ext[7:0];
    else                        cpu_din <= 8'hFF;
  end

  // Vertical-blank interrupt. A new assertion has priority over iack and
  // restarts the timeout count.
  logic [CW-1:0] int_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_n   <= 1'b1;
      int_cnt <= '0;
    end else if (lvbl_fall && dip_pause) begin
      int_n   <= 1'b0;
      int_cnt <= '0;
    end else if (!int_n) begin
      if (iack) begin
        int_n <= 1'b1;
      end else if (cpu_cen) begin
        if (int_cnt == CW'(INT_HOLD - 1)) int_n   <= 1'b1;
        else                              int_cnt <= int_cnt + 1'b1;
      end
    end
  end

endmodule
